// File: rtl/vpu_pkg.sv
// Shared VPU types and default widths used by the scratchpad and the VPU top.
package vpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } spad_state_t;

  localparam int VPU_DATA_W = 32;
  localparam int VPU_ADDR_W = 16;
  localparam int VPU_M      = 4;

endpackage

// File: rtl/vpu_spad_ram.sv
// Scratchpad storage: one write port, two registered read ports, no reset.
module vpu_spad_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reads sample the array before this edge's write lands: no forwarding.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/vpu_spad.sv
// VPU scratchpad: burst read lanes A/B, burst write lane C, idle-time host port.
// Optional range checking with sticky err is enabled by defining VPU_SPAD_ERR_EN.
//
// state    | meaning
// IDLE     | ready for a VPU burst; host port usable when no VPU request
// RD_BURST | presenting read beats 0..M-1 on lanes A/B
// WR_BURST | absorbing write beats 1..M-1 on lane C, stalls on ~wr_valid
module vpu_spad
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int ADDR_W = VPU_ADDR_W,
  parameter int DEPTH  = 32,
  parameter int M      = VPU_M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] data_c,
  input  logic              wr_valid,
  output logic              mem_rdy,
  output logic              mem_valid,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic              host_we,
  input  logic              host_re,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rdy,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(M - 1);

  spad_state_t       state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic              rd_bad_a, rd_bad_b, wr_bad, host_bad_q, host_rvalid_q, err_q;

  logic              bad_a, bad_b, bad_c, bad_h;
  logic              accept_rd, accept_wr, host_go, err_set;
  logic              vpu_we, ram_we;
  logic [ADDR_W-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [DATA_W-1:0] wr_data, q_a, q_b;

`ifdef VPU_SPAD_ERR_EN
  assign bad_a = (addr_a    >> IDX_W) != '0;
  assign bad_b = (addr_b    >> IDX_W) != '0;
  assign bad_c = (addr_c    >> IDX_W) != '0;
  assign bad_h = (host_addr >> IDX_W) != '0;
`else
  assign bad_a = 1'b0;
  assign bad_b = 1'b0;
  assign bad_c = 1'b0;
  assign bad_h = 1'b0;
`endif

  assign mem_rdy   = (state == IDLE) & ~rst;
  assign host_rdy  = mem_rdy & ~rd_req & ~wr_req;
  assign host_go   = host_rdy & (host_we | host_re);
  assign accept_wr = mem_rdy & wr_req;
  assign accept_rd = mem_rdy & ~wr_req & rd_req;
  assign err_set   = (accept_rd & (bad_a | bad_b)) | (accept_wr & bad_c) | (host_go & bad_h);

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    vpu_we    = 1'b0;
    wr_addr   = base_c + ADDR_W'(beat);
    wr_data   = data_c;
    rd_addr_a = host_addr;
    rd_addr_b = addr_b;
    case (state)
      IDLE: begin
        if (wr_req) begin
          vpu_we    = ~bad_c;
          wr_addr   = addr_c;
          state_nxt = (M == 1) ? IDLE : WR_BURST;
          beat_nxt  = (M == 1) ? '0 : BEAT_W'(1);
        end else begin
          wr_addr = host_addr;
          wr_data = host_wdata;
          if (rd_req) begin
            rd_addr_a = addr_a;
            state_nxt = RD_BURST;
            beat_nxt  = '0;
          end
        end
      end
      RD_BURST: begin
        // Prefetch the next beat so it is registered for the following cycle.
        rd_addr_a = base_a + ADDR_W'(beat) + ADDR_W'(1);
        rd_addr_b = base_b + ADDR_W'(beat) + ADDR_W'(1);
        if (beat == BEAT_LAST) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + BEAT_W'(1);
        end
      end
      WR_BURST: begin
        if (wr_valid) begin
          vpu_we = ~wr_bad;
          if (beat == BEAT_LAST) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_we = ~rst & (vpu_we | (host_rdy & host_we & ~bad_h));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat          <= '0;
      host_rvalid_q <= 1'b0;
      host_bad_q    <= 1'b0;
      err_q         <= 1'b0;
      rd_bad_a      <= 1'b0;
      rd_bad_b      <= 1'b0;
      wr_bad        <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat          <= beat_nxt;
      host_rvalid_q <= host_rdy & host_re;
      host_bad_q    <= bad_h;
      err_q         <= err_q | err_set;
      if (accept_rd) begin
        rd_bad_a <= bad_a;
        rd_bad_b <= bad_b;
      end
      if (accept_wr) wr_bad <= bad_c;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_rd) begin
      base_a <= addr_a;
      base_b <= addr_b;
    end
    if (accept_wr) base_c <= addr_c;
  end

  vpu_spad_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (wr_addr[IDX_W-1:0]),
    .wdata   (wr_data),
    .raddr_a (rd_addr_a[IDX_W-1:0]),
    .raddr_b (rd_addr_b[IDX_W-1:0]),
    .rdata_a (q_a),
    .rdata_b (q_b)
  );

  // Upper address bits only matter for the range check.
  logic unused_hi;
  assign unused_hi = ^{wr_addr[ADDR_W-1:IDX_W], rd_addr_a[ADDR_W-1:IDX_W], rd_addr_b[ADDR_W-1:IDX_W]};

  assign mem_valid   = (state == RD_BURST);
  assign data_a      = (mem_valid & ~rd_bad_a) ? q_a : '0;
  assign data_b      = (mem_valid & ~rd_bad_b) ? q_b : '0;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = (host_rvalid_q & ~host_bad_q) ? q_a : '0;
  assign err         = err_q;

endmodule

// File: tb/tb_vpu_spad.sv
// Self-checking bench for vpu_spad: shadow memory model plus expected-beat queues.
module tb_vpu_spad;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 32;
  localparam int M     = 4;
`ifdef VPU_SPAD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0, wr_req = 1'b0, wr_valid = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0, addr_c = '0, host_addr = '0;
  logic [DW-1:0] data_c = '0, host_wdata = '0;
  logic          host_we = 1'b0, host_re = 1'b0;
  logic          mem_rdy, mem_valid, host_rdy, host_rvalid, err;
  logic [DW-1:0] data_a, data_b, host_rdata;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] qa[$], qb[$], qh[$];
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vpu_spad dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .data_c(data_c),
    .wr_valid(wr_valid), .mem_rdy(mem_rdy), .mem_valid(mem_valid),
    .data_a(data_a), .data_b(data_b), .host_we(host_we), .host_re(host_re),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdy(host_rdy),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .err(err)
  );

  function automatic logic [DW-1:0] exp_word(input int base, input int k);
    if (ERR_EN && base >= DEPTH) return '0;
    return model[(base + k) % DEPTH];
  endfunction

  // Tasks start and end just after a falling edge.
  task automatic host_write(input int a, input logic [DW-1:0] d);
    host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
    @(posedge clk); #1 host_we = 1'b0;
    @(negedge clk);
    if (!(ERR_EN && a >= DEPTH)) model[a % DEPTH] = d;
  endtask

  task automatic test_host_read(input string name, input int a);
    logic [DW-1:0] e;
    host_re = 1'b1; host_addr = AW'(a);
    qh.push_back(exp_word(a, 0));
    #1;
    n_run++;
    if (host_rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s host_rdy: got %b want 1", name, host_rdy);
    end
    @(posedge clk); #1 host_re = 1'b0;
    @(negedge clk);
    n_run++;
    if (host_rvalid === 1'b1 && qh.size() > 0) begin
      e = qh.pop_front();
      if (host_rdata !== e) begin
        n_fail++; $display("FAIL %s data @%0d: got %h want %h", name, a, host_rdata, e);
      end
    end else begin
      n_fail++; $display("FAIL %s rvalid @%0d: got %b want 1", name, a, host_rvalid);
      qh.delete();
    end
  endtask

  task automatic test_read_burst(input string name, input int ba, input int bb);
    logic [DW-1:0] ea, eb;
    rd_req = 1'b1; addr_a = AW'(ba); addr_b = AW'(bb);
    for (int k = 0; k < M; k++) begin
      qa.push_back(exp_word(ba, k));
      qb.push_back(exp_word(bb, k));
    end
    #1;
    n_run++;
    if (mem_rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s accept mem_rdy: got %b want 1", name, mem_rdy);
    end
    @(posedge clk); #1 rd_req = 1'b0;
    for (int k = 0; k < M; k++) begin
      @(negedge clk);
      n_run++;
      if (mem_valid !== 1'b1 || mem_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s beat %0d handshake: valid=%b rdy=%b want 1/0", name, k, mem_valid, mem_rdy);
      end
      if (mem_valid === 1'b1 && qa.size() > 0) begin
        ea = qa.pop_front(); eb = qb.pop_front();
        n_run++;
        if (data_a !== ea || data_b !== eb) begin
          n_fail++;
          $display("FAIL %s beat %0d data: got a=%h b=%h want a=%h b=%h", name, k, data_a, data_b, ea, eb);
        end
      end
    end
    @(negedge clk);
    n_run++;
    if (mem_valid !== 1'b0 || mem_rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s end: valid=%b rdy=%b want 0/1", name, mem_valid, mem_rdy);
    end
    n_run++;
    if (qa.size() != 0) begin
      n_fail++; $display("FAIL %s leftover beats: got %0d want 0", name, qa.size());
      qa.delete(); qb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_run++;
    if (mem_rdy !== 1'b0 || host_rdy !== 1'b0 || mem_valid !== 1'b0 ||
        host_rvalid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ctl: rdy=%b hrdy=%b valid=%b hval=%b err=%b want 0s",
               mem_rdy, host_rdy, mem_valid, host_rvalid, err);
    end
    n_run++;
    if (data_a !== '0 || data_b !== '0 || host_rdata !== '0) begin
      n_fail++; $display("FAIL reset data: a=%h b=%h h=%h want 0", data_a, data_b, host_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if (mem_rdy !== 1'b1 || host_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset release: rdy=%b hrdy=%b want 1/1", mem_rdy, host_rdy);
    end
  endtask

  task automatic test_write_stall();
    logic [DW-1:0] w [M];
    for (int k = 0; k < M; k++) w[k] = 32'hA0 + DW'(k);
    wr_req = 1'b1; addr_c = 16'd10; data_c = w[0];
    @(posedge clk); #1 wr_req = 1'b0; wr_valid = 1'b1; data_c = w[1];
    @(posedge clk); #1 wr_valid = 1'b0; data_c = 32'hDEAD_BEEF;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      n_run++;
      if (mem_rdy !== 1'b0 || host_rdy !== 1'b0) begin
        n_fail++; $display("FAIL wr_stall %0d: rdy=%b hrdy=%b want 0/0", s, mem_rdy, host_rdy);
      end
    end
    @(posedge clk); #1 wr_valid = 1'b1; data_c = w[2];
    @(posedge clk); #1 data_c = w[3];
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if (mem_rdy !== 1'b1) begin
      n_fail++; $display("FAIL wr_stall done mem_rdy: got %b want 1", mem_rdy);
    end
    for (int k = 0; k < M; k++) model[10 + k] = w[k];
    for (int k = 0; k < M; k++) test_host_read("wr_stall_rd", 10 + k);
  endtask

  task automatic test_collision();
    logic [DW-1:0] ea, eb;
    rd_req = 1'b1; wr_req = 1'b1; wr_valid = 1'b0;
    addr_c = 16'd20; data_c = 32'hC0; addr_a = 16'd20; addr_b = 16'd22;
    for (int k = 0; k < M; k++) model[20 + k] = 32'hC0 + DW'(k);
    for (int k = 0; k < M; k++) begin
      qa.push_back(exp_word(20, k));
      qb.push_back(exp_word(22, k));
    end
    #1;
    n_run++;
    if (host_rdy !== 1'b0) begin
      n_fail++; $display("FAIL collide host_rdy at accept: got %b want 0", host_rdy);
    end
    for (int k = 1; k < M; k++) begin
      @(posedge clk); #1 wr_req = 1'b0; wr_valid = 1'b1; data_c = 32'hC0 + DW'(k);
      @(negedge clk);
      n_run++;
      if (mem_rdy !== 1'b0 || host_rdy !== 1'b0 || mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL collide wr beat %0d: rdy=%b hrdy=%b valid=%b want 0/0/0", k, mem_rdy, host_rdy, mem_valid);
      end
    end
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if (mem_rdy !== 1'b1 || host_rdy !== 1'b0) begin
      n_fail++; $display("FAIL collide idle: rdy=%b hrdy=%b want 1/0", mem_rdy, host_rdy);
    end
    @(posedge clk); #1 rd_req = 1'b0;
    for (int k = 0; k < M; k++) begin
      @(negedge clk);
      n_run++;
      if (mem_valid === 1'b1 && qa.size() > 0) begin
        ea = qa.pop_front(); eb = qb.pop_front();
        if (data_a !== ea || data_b !== eb) begin
          n_fail++;
          $display("FAIL collide rd beat %0d: got a=%h b=%h want a=%h b=%h", k, data_a, data_b, ea, eb);
        end
      end else begin
        n_fail++; $display("FAIL collide rd beat %0d valid: got %b want 1", k, mem_valid);
      end
    end
    @(negedge clk);
    n_run++;
    if (qa.size() != 0 || mem_rdy !== 1'b1) begin
      n_fail++; $display("FAIL collide end: left=%0d rdy=%b want 0/1", qa.size(), mem_rdy);
      qa.delete(); qb.delete();
    end
  endtask

  task automatic test_range();
    test_read_burst("range_rd40", 40, 2);
    n_run++;
    if (err !== ERR_EN) begin
      n_fail++; $display("FAIL range err after rd40: got %b want %b", err, ERR_EN);
    end
    test_read_burst("range_legal", 0, 1);
    n_run++;
    if (err !== ERR_EN) begin
      n_fail++; $display("FAIL range err sticky: got %b want %b", err, ERR_EN);
    end
    host_write(40, 32'h4040);
    test_host_read("range_hrd40", 40);
    test_host_read("range_hrd8", 8);
  endtask

  task automatic test_rst_mid_write();
    wr_req = 1'b1; addr_c = 16'd16; data_c = 32'hD0; wr_valid = 1'b0;
    @(posedge clk); #1 wr_req = 1'b0; wr_valid = 1'b1; data_c = 32'hD1;
    @(posedge clk); #1 data_c = 32'hD2; rst = 1'b1;
    @(negedge clk);
    n_run++;
    if (mem_rdy !== 1'b0 || host_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid in rst: rdy=%b hrdy=%b want 0/0", mem_rdy, host_rdy);
    end
    @(posedge clk); #1 rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if (mem_rdy !== 1'b1 || mem_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid after: rdy=%b valid=%b err=%b want 1/0/0", mem_rdy, mem_valid, err);
    end
    model[16] = 32'hD0;
    model[17] = 32'hD1;
    for (int k = 0; k < M; k++) test_host_read("rst_mid_rd", 16 + k);
  endtask

  task automatic test_host_same_cycle();
    logic [DW-1:0] e;
    host_we = 1'b1; host_re = 1'b1; host_addr = 16'd5; host_wdata = 32'h55;
    qh.push_back(model[5]);
    model[5] = 32'h55;
    @(posedge clk); #1 host_we = 1'b0; host_re = 1'b0;
    @(negedge clk);
    n_run++;
    if (host_rvalid === 1'b1 && qh.size() > 0) begin
      e = qh.pop_front();
      if (host_rdata !== e) begin
        n_fail++; $display("FAIL same_cycle old data: got %h want %h", host_rdata, e);
      end
    end else begin
      n_fail++; $display("FAIL same_cycle rvalid: got %b want 1", host_rvalid);
      qh.delete();
    end
    test_host_read("same_cycle_new", 5);
    @(negedge clk);
    n_run++;
    if (host_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL host rvalid pulse: got %b want 0", host_rvalid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    for (int i = 0; i < DEPTH; i++) host_write(i, 32'h100 + DW'(i));
    for (int i = 0; i < 8; i++) host_write(i, DW'(i + 1));
    test_read_burst("rd_base0_4", 0, 4);
    test_write_stall();
    test_collision();
    test_read_burst("rd_wrap30", 30, 0);
    test_range();
    test_rst_mid_write();
    test_host_same_cycle();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
